cordic_sequencer: RTL and testbench

Iterative CORDIC controller that owns one combinational cordic single-iteration stage and steps operands through it once per clock. It accepts an (x, y, z, mode) job over a valid/ready handshake and runs p_ITER micro-rotations. On each micro-rotation it feeds back the registered x/y/z, drives the shift amount and arctangent/arctanh LUT constant, and picks the rotation direction. It then presents the final vector on a held output handshake. It sits between the accelerator's operand front-end and its result/writeback logic.

---
 rtl/cordic_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cordic_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sequencer
// Description : Iterative CORDIC controller. Accepts an (x, y, z, mode, vec)
//               job over a valid/ready handshake, steps it through a single
//               combinational micro-rotation stage once per clock for p_ITER
//               iterations, then holds the final vector on a valid/ready
//               output handshake. Circular (mode=1) and hyperbolic (mode=0)
//               coordinate systems, rotation (vec=0) and vectoring (vec=1).
//               Optional macro CORDIC_SEQ_QUAD_EN adds a one-cycle PRE state
//               that folds circular operands into the convergence range with
//               a +/- pi/2 pre-rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_sequencer #(
    parameter int p_WIDTH = 32,
    parameter int p_FRAC  = 29,
    parameter int p_ITER  = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic signed [p_WIDTH-1:0] i_x,
    input  logic signed [p_WIDTH-1:0] i_y,
    input  logic signed [p_WIDTH-1:0] i_z,
    input  logic                      i_mode,
    input  logic                      i_vec,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic signed [p_WIDTH-1:0] o_x,
    output logic signed [p_WIDTH-1:0] o_y,
    output logic signed [p_WIDTH-1:0] o_z
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_KW    = $clog2(p_ITER + 1);
    localparam int c_SW    = $clog2(p_WIDTH);
    // Fractional precision used while building the angle table at elaboration.
    localparam int c_LUT_F = 100;

    localparam logic [1:0] c_IDLE = 2'd0;
`ifdef CORDIC_SEQ_QUAD_EN
    localparam logic [1:0] c_PRE  = 2'd1;
`endif
    localparam logic [1:0] c_ITER = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(p_ITER - 1);

    // atan(1/m) (or atanh(1/m) when hyp=1) as a c_LUT_F-bit fixed-point
    // value, via the Taylor series. Converges for any m >= 2; m=5 and m=239
    // feed the Machin formula for pi/4.
    function automatic logic [127:0] atan_inv_fx(input logic [127:0] m, input logic hyp);
        logic [127:0] p;
        logic [127:0] msq;
        logic [127:0] sum;
        logic [127:0] term;
        sum = '0;
        msq = m * m;
        p   = (128'd1 << c_LUT_F) / m;
        for (int n = 0; n < 64; n++) begin
            term = p / 128'(2 * n + 1);
            if (hyp || ((n % 2) == 0)) begin
                sum = sum + term;
            end else begin
                sum = sum - term;
            end
            p = p / msq;
        end
        return sum;
    endfunction

    // pi/4 = 4*atan(1/5) - atan(1/239), in c_LUT_F-bit fixed point.
    function automatic logic [127:0] pi_quarter_fx();
        return (atan_inv_fx(128'd5, 1'b0) << 2) - atan_inv_fx(128'd239, 1'b0);
    endfunction

    // Round a c_LUT_F-bit fixed-point value to p_FRAC fractional bits.
    function automatic logic [p_WIDTH-1:0] fx_round(input logic [127:0] v);
        logic [127:0] r;
        r = (v + (128'd1 << (c_LUT_F - p_FRAC - 1))) >> (c_LUT_F - p_FRAC);
        return r[p_WIDTH-1:0];
    endfunction

    // Table entry for shift amount s. Hyperbolic s=0 is never scheduled.
    function automatic logic [p_WIDTH-1:0] lut_entry(input int s, input logic hyp);
        logic [127:0] v;
        if (s == 0) begin
            if (hyp) begin
                v = '0;
            end else begin
                v = pi_quarter_fx();
            end
        end else begin
            v = atan_inv_fx(128'd1 << s, hyp);
        end
        return fx_round(v);
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]                r_state;
    logic [c_KW-1:0]           r_k;
    logic signed [p_WIDTH-1:0] r_x;
    logic signed [p_WIDTH-1:0] r_y;
    logic signed [p_WIDTH-1:0] r_z;
    logic                      r_mode;
    logic                      r_vec;

    // ------------------------------------------------------------------------
    // Arctangent / arctanh tables, indexed by shift amount
    // ------------------------------------------------------------------------
    logic signed [p_WIDTH-1:0] w_atan_tab  [p_WIDTH];
    logic signed [p_WIDTH-1:0] w_atanh_tab [p_WIDTH];

    generate
        for (genvar gi = 0; gi < p_WIDTH; gi++) begin : g_lut
            localparam logic signed [p_WIDTH-1:0] c_ATAN  = lut_entry(gi, 1'b0);
            localparam logic signed [p_WIDTH-1:0] c_ATANH = lut_entry(gi, 1'b1);
            assign w_atan_tab[gi]  = c_ATAN;
            assign w_atanh_tab[gi] = c_ATANH;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Shift schedule
    // ------------------------------------------------------------------------
    logic [31:0]     w_k_ext;
    logic [31:0]     w_shift_raw;
    logic [c_SW-1:0] w_shift;

    // Map iteration index to shift amount; hyperbolic repeats 4, 13 and 40.
    always_comb begin
        w_k_ext = 32'(r_k);
        if (r_mode) begin
            w_shift_raw = w_k_ext;
        end else if (w_k_ext < 32'd4) begin
            w_shift_raw = w_k_ext + 32'd1;
        end else if (w_k_ext < 32'd14) begin
            w_shift_raw = w_k_ext;
        end else if (w_k_ext < 32'd42) begin
            w_shift_raw = w_k_ext - 32'd1;
        end else begin
            w_shift_raw = w_k_ext - 32'd2;
        end
        if (w_shift_raw > 32'(p_WIDTH - 1)) begin
            w_shift = c_SW'(p_WIDTH - 1);
        end else begin
            w_shift = w_shift_raw[c_SW-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Single micro-rotation stage
    // ------------------------------------------------------------------------
    logic                      w_d;
    logic signed [p_WIDTH-1:0] w_xs;
    logic signed [p_WIDTH-1:0] w_ys;
    logic signed [p_WIDTH-1:0] w_lut;
    logic signed [p_WIDTH-1:0] w_x_nxt;
    logic signed [p_WIDTH-1:0] w_y_nxt;
    logic signed [p_WIDTH-1:0] w_z_nxt;

    // One CORDIC step: d=1 means rotate by +angle (z decreases).
    always_comb begin
        w_d   = r_vec ? r_y[p_WIDTH-1] : ~r_z[p_WIDTH-1];
        w_xs  = r_x >>> w_shift;
        w_ys  = r_y >>> w_shift;
        w_lut = r_mode ? w_atan_tab[w_shift] : w_atanh_tab[w_shift];
        if (r_mode) begin
            w_x_nxt = w_d ? (r_x - w_ys) : (r_x + w_ys);
        end else begin
            w_x_nxt = w_d ? (r_x + w_ys) : (r_x - w_ys);
        end
        w_y_nxt = w_d ? (r_y + w_xs) : (r_y - w_xs);
        w_z_nxt = w_d ? (r_z - w_lut) : (r_z + w_lut);
    end

`ifdef CORDIC_SEQ_QUAD_EN
    // ------------------------------------------------------------------------
    // Quadrant pre-rotation (circular only)
    // ------------------------------------------------------------------------
    localparam logic signed [p_WIDTH-1:0] c_HALF_PI = fx_round(pi_quarter_fx() << 1);

    logic signed [p_WIDTH-1:0] w_pre_x;
    logic signed [p_WIDTH-1:0] w_pre_y;
    logic signed [p_WIDTH-1:0] w_pre_z;
    logic                      w_rot_pos;
    logic                      w_rot_neg;

    // Fold the operand by +/- 90 degrees so the main iterations converge.
    always_comb begin
        w_rot_pos = 1'b0;
        w_rot_neg = 1'b0;
        if (r_mode) begin
            if (r_vec) begin
                w_rot_neg = r_x[p_WIDTH-1] & ~r_y[p_WIDTH-1];
                w_rot_pos = r_x[p_WIDTH-1] &  r_y[p_WIDTH-1];
            end else begin
                w_rot_pos = (r_z > c_HALF_PI);
                w_rot_neg = (r_z < -c_HALF_PI);
            end
        end
        if (w_rot_pos) begin
            w_pre_x = -r_y;
            w_pre_y = r_x;
            w_pre_z = r_z - c_HALF_PI;
        end else if (w_rot_neg) begin
            w_pre_x = r_y;
            w_pre_y = -r_x;
            w_pre_z = r_z + c_HALF_PI;
        end else begin
            w_pre_x = r_x;
            w_pre_y = r_y;
            w_pre_z = r_z;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    // Sequence a job: capture, optional pre-rotation, iterate, hold result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_k     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_mode  <= 1'b0;
            r_vec   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (i_valid) begin
                        r_x    <= i_x;
                        r_y    <= i_y;
                        r_z    <= i_z;
                        r_mode <= i_mode;
                        r_vec  <= i_vec;
                        r_k    <= '0;
`ifdef CORDIC_SEQ_QUAD_EN
                        r_state <= c_PRE;
`else
                        r_state <= c_ITER;
`endif
                    end
                end
`ifdef CORDIC_SEQ_QUAD_EN
                c_PRE: begin
                    r_x     <= w_pre_x;
                    r_y     <= w_pre_y;
                    r_z     <= w_pre_z;
                    r_state <= c_ITER;
                end
`endif
                c_ITER: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    r_k <= r_k + 1'b1;
                    if (r_k == c_K_LAST) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (i_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_ready = (r_state == c_IDLE);
    assign o_valid = (r_state == c_DONE);
    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_z     = r_z;

endmodule
`default_nettype wire

// File: tb/tb_cordic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_sequencer
// Description : Self-checking bench for cordic_sequencer. Expected results are
//               derived from real-valued trig/hyperbolic math and the CORDIC
//               gain, pushed to a scoreboard at job issue and compared when
//               o_valid rises. Honours CORDIC_SEQ_QUAD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_sequencer;

    localparam int  W   = 32;
    localparam int  F   = 29;
    localparam int  N   = 24;
    localparam int  TOL = 256;
    localparam real ONE = 536870912.0;
    localparam real PI  = 3.14159265358979323846;
`ifdef CORDIC_SEQ_QUAD_EN
    localparam int  LAT = N + 2;
`else
    localparam int  LAT = N + 1;
`endif

    logic                clk     = 1'b0;
    logic                rst     = 1'b1;
    logic                i_valid = 1'b0;
    logic                i_mode  = 1'b0;
    logic                i_vec   = 1'b0;
    logic                i_ready = 1'b1;
    logic signed [W-1:0] i_x     = '0;
    logic signed [W-1:0] i_y     = '0;
    logic signed [W-1:0] i_z     = '0;
    logic                o_ready;
    logic                o_valid;
    logic signed [W-1:0] o_x;
    logic signed [W-1:0] o_y;
    logic signed [W-1:0] o_z;

    always #5 clk = ~clk;

    cordic_sequencer #(
        .p_WIDTH (W),
        .p_FRAC  (F),
        .p_ITER  (N)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_x     (i_x),
        .i_y     (i_y),
        .i_z     (i_z),
        .i_mode  (i_mode),
        .i_vec   (i_vec),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_x     (o_x),
        .o_y     (o_y),
        .o_z     (o_z)
    );

    typedef struct {
        longint x;
        longint y;
        longint z;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    real  kc       = 1.0;
    real  kh       = 1.0;

    task automatic chk_eq(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_near(input string tag, input longint obs, input longint expv);
        longint d;
        d = obs - expv;
        if (d < 0) d = -d;
        checks++;
        assert (d <= TOL) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (tol %0d)", tag, obs, expv, TOL);
        end
    endtask

    // Ideal result of an N-iteration CORDIC including its (uncompensated) gain.
    function automatic exp_t model(input longint x, input longint y, input longint z,
                                   input bit mode, input bit vec);
        exp_t e;
        real xr, yr, zr, ox, oy, oz;
        xr = real'(x) / ONE;
        yr = real'(y) / ONE;
        zr = real'(z) / ONE;
        if (mode && !vec) begin
            ox = kc * (xr * $cos(zr) - yr * $sin(zr));
            oy = kc * (yr * $cos(zr) + xr * $sin(zr));
            oz = 0.0;
        end else if (mode) begin
            ox = kc * $sqrt(xr * xr + yr * yr);
            oy = 0.0;
            oz = zr + $atan2(yr, xr);
        end else if (!vec) begin
            ox = kh * (xr * $cosh(zr) + yr * $sinh(zr));
            oy = kh * (yr * $cosh(zr) + xr * $sinh(zr));
            oz = 0.0;
        end else begin
            ox = kh * $sqrt(xr * xr - yr * yr);
            oy = 0.0;
            oz = zr + $atanh(yr / xr);
        end
        e.x = longint'(ox * ONE);
        e.y = longint'(oy * ONE);
        e.z = longint'(oz * ONE);
        return e;
    endfunction

    // Issue one job, wait for the result, score it; optional output backpressure.
    task automatic run_job(input string tag, input logic signed [W-1:0] x,
                           input logic signed [W-1:0] y, input logic signed [W-1:0] z,
                           input logic mode, input logic vec, input int hold);
        int     lat;
        exp_t   g;
        longint sx, sy, sz;
        chk_eq({tag, "_ready_in"}, o_ready, 1);
        i_x     = x;
        i_y     = y;
        i_z     = z;
        i_mode  = mode;
        i_vec   = vec;
        i_ready = (hold == 0);
        i_valid = 1'b1;
        sb.push_back(model(x, y, z, mode, vec));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        lat     = 1;
        while (!o_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_eq({tag, "_latency"}, lat, LAT);
        if (o_valid && sb.size() > 0) begin
            g = sb.pop_front();
            chk_near({tag, "_x"}, o_x, g.x);
            chk_near({tag, "_y"}, o_y, g.y);
            chk_near({tag, "_z"}, o_z, g.z);
        end
        sx = o_x;
        sy = o_y;
        sz = o_z;
        for (int c = 0; c < hold; c++) begin
            if (c == 3) begin
                i_x     = 32'sd123456;
                i_valid = 1'b1;
            end
            if (c == 4) i_valid = 1'b0;
            @(posedge clk);
            #1;
            chk_eq({tag, "_bp_valid"}, o_valid, 1);
            chk_eq({tag, "_bp_ready"}, o_ready, 0);
            chk_eq({tag, "_bp_x"}, o_x, sx);
            chk_eq({tag, "_bp_y"}, o_y, sy);
            chk_eq({tag, "_bp_z"}, o_z, sz);
        end
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_eq({tag, "_release_valid"}, o_valid, 0);
        chk_eq({tag, "_release_ready"}, o_ready, 1);
    endtask

    initial begin
        int s;
        bit rep;
        for (int k = 0; k < N; k++) kc = kc * $sqrt(1.0 + $pow(2.0, -2.0 * k));
        s   = 1;
        rep = 1'b0;
        for (int k = 0; k < N; k++) begin
            kh = kh * $sqrt(1.0 - $pow(2.0, -2.0 * s));
            if ((s == 4 || s == 13 || s == 40) && !rep) begin
                rep = 1'b1;
            end else begin
                rep = 1'b0;
                s++;
            end
        end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_ready", o_ready, 1);
        chk_eq("rst_valid", o_valid, 0);
        chk_eq("rst_x", o_x, 0);
        chk_eq("rst_y", o_y, 0);
        chk_eq("rst_z", o_z, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Circular rotation by pi/4
        run_job("crot", 32'sh136E9DB5, 32'sd0, 32'sh1921FB54, 1'b1, 1'b0, 0);
        // Circular vectoring of (0.5, 0.5)
        run_job("cvec", 32'sh10000000, 32'sh10000000, 32'sd0, 1'b1, 1'b1, 0);
        // Hyperbolic rotation by 0.5
        run_job("hrot", 32'sd648270016, 32'sd0, 32'sh10000000, 1'b0, 1'b0, 0);
        // Negative angle with 10 cycles of output backpressure
        run_job("bp", 32'sh136E9DB5, 32'sd0, -32'sd322122547, 1'b1, 1'b0, 10);
        // The pulse offered during backpressure must not have started a job
        repeat (N + 4) @(posedge clk);
        #1;
        chk_eq("bp_ignored_ready", o_ready, 1);
        chk_eq("bp_ignored_valid", o_valid, 0);

        // Reset in the middle of iteration (k=7)
        i_x     = 32'sh136E9DB5;
        i_y     = 32'sd0;
        i_z     = 32'sh0C90FDAA;
        i_mode  = 1'b1;
        i_vec   = 1'b0;
        i_valid = 1'b1;
        sb.push_back(model(32'sh136E9DB5, 0, 32'sh0C90FDAA, 1'b1, 1'b0));
        @(posedge clk);
        #1;
        i_valid = 1'b0;
`ifdef CORDIC_SEQ_QUAD_EN
        repeat (8) @(posedge clk);
`else
        repeat (7) @(posedge clk);
`endif
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("abort_ready", o_ready, 1);
        chk_eq("abort_valid", o_valid, 0);
        chk_eq("abort_x", o_x, 0);
        chk_eq("abort_y", o_y, 0);
        chk_eq("abort_z", o_z, 0);
        repeat (N + 4) @(posedge clk);
        #1;
        chk_eq("abort_no_result", o_valid, 0);

        // Fresh job after the abort: vectoring of (0.75, -0.25)
        run_job("post_rst", 32'sh18000000, -32'sh08000000, 32'sd0, 1'b1, 1'b1, 0);

`ifdef CORDIC_SEQ_QUAD_EN
        // Rotation by 3*pi/4, outside the native convergence range
        run_job("quad", 32'sh136E9DB5, 32'sd0, 32'(longint'(3.0 * PI / 4.0 * ONE)),
                1'b1, 1'b0, 0);
`endif

        chk_eq("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
